// File: rtl/mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_responder: unified instruction/data word memory with a fixed   |
// | wait-state latency and a one-cycle ready pulse per access.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int         C_DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] C_LOAD  = 4'(LATENCY - 1);

  logic [31:0]          r_mem [C_DEPTH];
  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_idx;
  logic [31:0]          r_wdata;
  logic                 r_is_write;

  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_unused;

  // Byte offset and bits above the array depth are dropped, so addresses alias.
  assign w_idx    = addr[ADDR_BITS+1:2];
  assign w_unused = &{1'b0, addr[1:0], addr[31:ADDR_BITS+2]};
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_is_write <= 1'b0;
      read_data  <= 32'd0;
      ready      <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mem_read | mem_write) begin
            r_idx      <= w_idx;
            r_wdata    <= write_data;
            r_is_write <= mem_write;
            r_cnt      <= C_LOAD;
            if (C_LOAD == 4'd0) begin
              r_state <= S_DONE;
              ready   <= 1'b1;
              if (!mem_write) read_data <= r_mem[w_idx];
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // Entering DONE on the edge where the count runs out keeps ready at LATENCY cycles.
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= S_DONE;
            ready   <= 1'b1;
            if (!r_is_write) read_data <= r_mem[r_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A reset during the access drops the state out of DONE, so no commit happens.
  always_ff @(posedge clk) begin
    if (r_state == S_DONE && r_is_write) r_mem[r_idx] <= r_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_responder: directed self-checking bench, LATENCY=2 and 1.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        rd, wr, rd1, wr1;
  logic [31:0] addr, wd, addr1, wd1;
  logic [31:0] rdata, rdata1;
  logic        rdy, bsy, rdy1, bsy1;

  int n_cmp;
  int n_bad;
  logic [31:0] exp_rd;

  mem_responder #(.ADDR_BITS(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .mem_read(rd), .mem_write(wr), .addr(addr),
    .write_data(wd), .read_data(rdata), .ready(rdy), .busy(bsy)
  );

  mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .addr(addr1),
    .write_data(wd1), .read_data(rdata1), .ready(rdy1), .busy(bsy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on the LATENCY=2 instance; noisy drives strobes and new addr/data while BUSY.
  task automatic acc2(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic noisy, input string tag);
    rd = r; wr = w; addr = a; wd = d;
    tick();
    rd = noisy; wr = noisy; addr = 32'h0000_003C; wd = 32'hFFFF_FFFF;
    check_eq({tag, "_busy1"}, {31'd0, bsy}, 32'd1);
    check_eq({tag, "_rdy1"},  {31'd0, rdy}, 32'd0);
    tick();
    rd = 1'b0; wr = 1'b0;
    check_eq({tag, "_rdy2"},  {31'd0, rdy}, 32'd1);
    check_eq({tag, "_busy2"}, {31'd0, bsy}, 32'd1);
    check_eq({tag, "_rdata_done"}, rdata, exp_rd);
    tick();
    check_eq({tag, "_rdy3"},  {31'd0, rdy}, 32'd0);
    check_eq({tag, "_busy3"}, {31'd0, bsy}, 32'd0);
    check_eq({tag, "_rdata_after"}, rdata, exp_rd);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; exp_rd = 32'd0;
    rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'd0; wd = 32'd0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wd1 = 32'd0;
    tick(); tick();
    check_eq("rst_busy",  {31'd0, bsy}, 32'd0);
    check_eq("rst_ready", {31'd0, rdy}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    rst = 1'b1;
    tick();

    // Known background contents
    acc2(1'b0, 1'b1, 32'h10, 32'h1111_1111, 1'b0, "pre10");
    acc2(1'b0, 1'b1, 32'h3C, 32'h3333_3333, 1'b0, "pre3c");

    // Reset in the middle of a write
    wr = 1'b1; addr = 32'h10; wd = 32'hDEAD_BEEF;
    tick();
    wr = 1'b0;
    check_eq("t1_busy_pre", {31'd0, bsy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("t1_busy_rst",  {31'd0, bsy}, 32'd0);
    check_eq("t1_rdy_rst",   {31'd0, rdy}, 32'd0);
    check_eq("t1_rdata_rst", rdata, 32'd0);
    tick();
    check_eq("t1_rdy_hold", {31'd0, rdy}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    exp_rd = 32'h1111_1111;
    acc2(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, "t1_rd10");

    // Basic write then read, and hold across a later write
    acc2(1'b0, 1'b1, 32'h24, 32'h1234_5678, 1'b0, "t2_wr");
    exp_rd = 32'h1234_5678;
    acc2(1'b1, 1'b0, 32'h24, 32'd0, 1'b0, "t2_rd");
    acc2(1'b0, 1'b1, 32'h28, 32'h5555_5555, 1'b0, "t2_hold");

    // Aliasing: 0x1003 maps to word 0
    acc2(1'b0, 1'b1, 32'h0000_1003, 32'hA5A5_A5A5, 1'b0, "t4_wr");
    exp_rd = 32'hA5A5_A5A5;
    acc2(1'b1, 1'b0, 32'h0, 32'd0, 1'b0, "t4_rd");

    // Simultaneous read and write strobes behave as a write
    acc2(1'b1, 1'b1, 32'h8, 32'h0BAD_F00D, 1'b0, "t5_both");
    exp_rd = 32'h0BAD_F00D;
    acc2(1'b1, 1'b0, 32'h8, 32'd0, 1'b0, "t5_rd");

    // Strobes and inputs wiggled during BUSY
    acc2(1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, 1'b1, "t6_wr");
    exp_rd = 32'hCAFE_F00D;
    acc2(1'b1, 1'b0, 32'h30, 32'd0, 1'b1, "t6_rd30");
    exp_rd = 32'h3333_3333;
    acc2(1'b1, 1'b0, 32'h3C, 32'd0, 1'b0, "t6_rd3c");

    // LATENCY=1 instance
    wr1 = 1'b1; addr1 = 32'h40; wd1 = 32'h7777_7777;
    tick();
    wr1 = 1'b0;
    check_eq("t3_wr_rdy",  {31'd0, rdy1}, 32'd1);
    check_eq("t3_wr_busy", {31'd0, bsy1}, 32'd1);
    tick();
    check_eq("t3_wr_idle", {31'd0, bsy1}, 32'd0);
    rd1 = 1'b1; addr1 = 32'h40;
    tick();
    check_eq("t3_rd_rdy1",  {31'd0, rdy1}, 32'd1);
    check_eq("t3_rd_data1", rdata1, 32'h7777_7777);
    tick();
    check_eq("t3_gap_rdy",  {31'd0, rdy1}, 32'd0);
    check_eq("t3_gap_busy", {31'd0, bsy1}, 32'd0);
    tick();
    rd1 = 1'b0;
    check_eq("t3_rd_rdy2",  {31'd0, rdy1}, 32'd1);
    check_eq("t3_rd_data2", rdata1, 32'h7777_7777);
    tick();
    check_eq("t3_end_rdy",  {31'd0, rdy1}, 32'd0);
    check_eq("t3_end_busy", {31'd0, bsy1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
